// File: rtl/instr_fetch_buffer.sv
// Sequential instruction prefetch buffer: issues word reads to a 1-cycle RAM wrapper, buffers them, handles redirects.
// Define FETCH_BUF_FALLTHROUGH_EN to present a returning word in the same cycle when the FIFO is empty.
module instr_fetch_buffer #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 16'h8000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en_i,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_addr_i,
    output logic                  fetch_valid_o,
    input  logic                  fetch_ready_i,
    output logic [DATA_WIDTH-1:0] fetch_rdata_o,
    output logic [ADDR_WIDTH-1:0] fetch_addr_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] infl_addr_q, infl_addr_d;
    logic                  infl_q, infl_d;
    logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] branch_tgt;
    logic                  fifo_empty;
    logic                  ft_valid;
    logic                  pop;
    logic                  pop_fifo;
    logic                  ft_take;
    logic                  wr_en;
    logic                  issue_seq;
    logic [CW:0]           occ;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^branch_addr_i[1:0];
    assign branch_tgt       = {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign fifo_empty       = (cnt_q == '0);

`ifdef FETCH_BUF_FALLTHROUGH_EN
    assign ft_valid = fifo_empty & infl_q;
`else
    assign ft_valid = 1'b0;
`endif

    // Head word: buffered entry first, otherwise the returning word (fall-through only), otherwise zero.
    always_comb begin
        fetch_rdata_o = '0;
        fetch_addr_o  = '0;
        if (!fifo_empty) begin
            fetch_rdata_o = data_mem[rd_q];
            fetch_addr_o  = addr_mem[rd_q];
        end
`ifdef FETCH_BUF_FALLTHROUGH_EN
        else if (ft_valid) begin
            fetch_rdata_o = mem_rdata_i;
            fetch_addr_o  = infl_addr_q;
        end
`endif
    end

    assign fetch_valid_o = ~branch_i & (~fifo_empty | ft_valid);
    assign pop           = fetch_valid_o & fetch_ready_i;
    assign pop_fifo      = pop & ~fifo_empty;
    assign ft_take       = pop & fifo_empty;
    assign wr_en         = infl_q & ~branch_i & ~ft_take;

    // Occupancy after this cycle's pop; never underflows because pop implies a buffered or in-flight word.
    assign occ       = {1'b0, cnt_q} + (CW+1)'(infl_q) - (CW+1)'(pop);
    assign issue_seq = fetch_en_i & (occ < (CW+1)'(DEPTH));

    assign mem_en_o   = rst_n & (branch_i ? fetch_en_i : issue_seq);
    assign mem_addr_o = (rst_n & branch_i) ? branch_tgt : pc_q;

    always_comb begin
        pc_d        = pc_q;
        infl_d      = infl_q;
        infl_addr_d = infl_addr_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        if (branch_i) begin
            rd_d        = '0;
            wr_d        = '0;
            cnt_d       = '0;
            infl_d      = fetch_en_i;
            infl_addr_d = branch_tgt;
            pc_d        = fetch_en_i ? branch_tgt + ADDR_WIDTH'(4) : branch_tgt;
        end else begin
            infl_d = issue_seq;
            if (issue_seq) begin
                pc_d        = pc_q + ADDR_WIDTH'(4);
                infl_addr_d = pc_q;
            end
            if (wr_en) begin
                wr_d = wr_q + PW'(1);
            end
            if (pop_fifo) begin
                rd_d = rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(wr_en) - CW'(pop_fifo);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= BOOT_ADDR;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
        end else begin
            pc_q        <= pc_d;
            infl_q      <= infl_d;
            infl_addr_q <= infl_addr_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            addr_mem[wr_q] <= infl_addr_q;
            data_mem[wr_q] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: directed scenarios plus a randomized run against a stream-level model.
`timescale 1ns/1ps
module tb_instr_fetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [15:0] BOOT  = 16'h8000;
`ifdef FETCH_BUF_FALLTHROUGH_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [15:0] branch_addr_i = '0;
    logic        fetch_valid_o;
    logic        fetch_ready_i = 1'b0;
    logic [31:0] fetch_rdata_o;
    logic [15:0] fetch_addr_o;
    logic        mem_en_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_rdata_i = '0;

    int checks = 0;
    int failures = 0;

    instr_fetch_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en_i    (fetch_en_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .fetch_valid_o (fetch_valid_o),
        .fetch_ready_i (fetch_ready_i),
        .fetch_rdata_o (fetch_rdata_o),
        .fetch_addr_o  (fetch_addr_o),
        .mem_en_o      (mem_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return {a ^ 16'hC35A, ~a};
    endfunction

    // RAM wrapper: one-cycle read latency
    always @(posedge clk) begin
        if (mem_en_o) mem_rdata_i <= word_of(mem_addr_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_en_i = 1'b0;
        fetch_ready_i = 1'b0;
        branch_i = 1'b0;
        branch_addr_i = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_en_i = 1'b1;
        fetch_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", fetch_valid_o); end
        checks++; if (fetch_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", fetch_rdata_o); end
        checks++; if (fetch_addr_o !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", fetch_addr_o); end
        checks++; if (mem_en_o !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0", mem_en_o); end
        checks++; if (mem_addr_o !== BOOT) begin failures++; $display("FAIL reset_mem_addr got=%h exp=%h", mem_addr_o, BOOT); end
        tick();
    endtask

    task automatic test_stream();
        logic [15:0] exp;
        do_reset();
        fetch_en_i = 1'b1;
        fetch_ready_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (mem_en_o !== 1'b1 || mem_addr_o !== BOOT + 16'(4*c)) begin
                failures++; $display("FAIL stream_issue cyc=%0d got en=%b addr=%h exp addr=%h", c, mem_en_o, mem_addr_o, BOOT + 16'(4*c));
            end
            checks++;
            if (fetch_valid_o !== (c >= LAT)) begin
                failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", c, fetch_valid_o, (c >= LAT));
            end
            if (c >= LAT) begin
                exp = BOOT + 16'(4*(c-LAT));
                checks++;
                if (fetch_addr_o !== exp || fetch_rdata_o !== word_of(exp)) begin
                    failures++; $display("FAIL stream_word cyc=%0d got %h/%h exp %h/%h", c, fetch_addr_o, fetch_rdata_o, exp, word_of(exp));
                end
            end
            tick();
        end
    endtask

    task automatic test_full();
        int n_iss = 0;
        do_reset();
        fetch_en_i = 1'b1;
        fetch_ready_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_en_o) begin
                checks++;
                if (mem_addr_o !== BOOT + 16'(4*n_iss)) begin
                    failures++; $display("FAIL full_issue_addr n=%0d got=%h exp=%h", n_iss, mem_addr_o, BOOT + 16'(4*n_iss));
                end
                n_iss++;
            end
            if (fetch_valid_o) begin
                checks++;
                if (fetch_addr_o !== BOOT || fetch_rdata_o !== word_of(BOOT)) begin
                    failures++; $display("FAIL full_head_hold cyc=%0d got %h/%h exp %h/%h", c, fetch_addr_o, fetch_rdata_o, BOOT, word_of(BOOT));
                end
            end
            tick();
        end
        checks++; if (n_iss != DEPTH) begin failures++; $display("FAIL full_issue_count got=%0d exp=%0d", n_iss, DEPTH); end
        @(negedge clk);
        checks++; if (mem_en_o !== 1'b0) begin failures++; $display("FAIL full_mem_en got=%b exp=0", mem_en_o); end
        checks++; if (fetch_valid_o !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", fetch_valid_o); end
        tick();
    endtask

    task automatic test_branch();
        int got = 0;
        logic [15:0] exp;
        do_reset();
        fetch_en_i = 1'b1;
        fetch_ready_i = 1'b0;
        repeat (4) begin @(negedge clk); tick(); end
        branch_i = 1'b1;
        branch_addr_i = 16'h0102;
        fetch_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL branch_valid_forced got=%b exp=0", fetch_valid_o); end
        checks++;
        if (mem_en_o !== 1'b1 || mem_addr_o !== 16'h0100) begin
            failures++; $display("FAIL branch_issue got en=%b addr=%h exp addr=0100", mem_en_o, mem_addr_o);
        end
        tick();
        branch_i = 1'b0;
        for (int c = 0; c < 8 && got < 2; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (fetch_valid_o !== (LAT == 1)) begin failures++; $display("FAIL branch_after_valid got=%b exp=%b", fetch_valid_o, (LAT == 1)); end
            end
            if (fetch_valid_o) begin
                exp = 16'h0100 + 16'(4*got);
                checks++;
                if (fetch_addr_o !== exp || fetch_rdata_o !== word_of(exp)) begin
                    failures++; $display("FAIL branch_word n=%0d got %h/%h exp %h/%h", got, fetch_addr_o, fetch_rdata_o, exp, word_of(exp));
                end
                got++;
            end
            tick();
        end
        checks++; if (got != 2) begin failures++; $display("FAIL branch_delivered got=%0d exp=2", got); end
    endtask

    task automatic test_fetch_disable();
        int got = 0;
        logic [15:0] exp;
        do_reset();
        fetch_en_i = 1'b1;
        fetch_ready_i = 1'b0;
        repeat (2) begin @(negedge clk); tick(); end
        fetch_en_i = 1'b0;
        fetch_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (mem_en_o !== 1'b0) begin failures++; $display("FAIL dis_mem_en cyc=%0d got=%b exp=0", c, mem_en_o); end
            if (fetch_valid_o) begin
                exp = BOOT + 16'(4*got);
                checks++;
                if (fetch_addr_o !== exp || fetch_rdata_o !== word_of(exp)) begin
                    failures++; $display("FAIL dis_word n=%0d got %h/%h exp %h/%h", got, fetch_addr_o, fetch_rdata_o, exp, word_of(exp));
                end
                got++;
            end
            tick();
        end
        checks++; if (got != 2) begin failures++; $display("FAIL dis_delivered got=%0d exp=2", got); end
        @(negedge clk);
        checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL dis_drained got=%b exp=0", fetch_valid_o); end
        tick();
    endtask

    task automatic test_wrap();
        int got = 0;
        logic [15:0] exp;
        do_reset();
        fetch_en_i = 1'b1;
        fetch_ready_i = 1'b1;
        branch_i = 1'b1;
        branch_addr_i = 16'hFFFC;
        @(negedge clk);
        checks++;
        if (mem_en_o !== 1'b1 || mem_addr_o !== 16'hFFFC) begin
            failures++; $display("FAIL wrap_issue0 got en=%b addr=%h exp addr=fffc", mem_en_o, mem_addr_o);
        end
        tick();
        branch_i = 1'b0;
        for (int c = 0; c < 8 && got < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (mem_en_o !== 1'b1 || mem_addr_o !== 16'h0000) begin
                    failures++; $display("FAIL wrap_issue1 got en=%b addr=%h exp addr=0000", mem_en_o, mem_addr_o);
                end
            end
            if (fetch_valid_o) begin
                exp = 16'hFFFC + 16'(4*got);
                checks++;
                if (fetch_addr_o !== exp || fetch_rdata_o !== word_of(exp)) begin
                    failures++; $display("FAIL wrap_word n=%0d got %h/%h exp %h/%h", got, fetch_addr_o, fetch_rdata_o, exp, word_of(exp));
                end
                got++;
            end
            tick();
        end
        checks++; if (got != 3) begin failures++; $display("FAIL wrap_delivered got=%0d exp=3", got); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        do_reset();
        fetch_en_i = 1'b1;
        fetch_ready_i = 1'b0;
        repeat (6) begin @(negedge clk); tick(); end
        @(negedge clk);
        checks++;
        if (fetch_valid_o !== 1'b1 || mem_en_o !== 1'b0) begin
            failures++; $display("FAIL mid_full got valid=%b en=%b exp valid=1 en=0", fetch_valid_o, mem_en_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", fetch_valid_o); end
        checks++; if (fetch_rdata_o !== 32'h0 || fetch_addr_o !== 16'h0) begin failures++; $display("FAIL mid_rst_head got %h/%h exp 0/0", fetch_addr_o, fetch_rdata_o); end
        checks++; if (mem_en_o !== 1'b0 || mem_addr_o !== BOOT) begin failures++; $display("FAIL mid_rst_mem got en=%b addr=%h exp en=0 addr=%h", mem_en_o, mem_addr_o, BOOT); end
        tick();
        tick();
        rst_n = 1'b1;
        fetch_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (mem_en_o !== 1'b1 || mem_addr_o !== BOOT) begin
                    failures++; $display("FAIL mid_restart got en=%b addr=%h exp addr=%h", mem_en_o, mem_addr_o, BOOT);
                end
            end
            checks++;
            if (fetch_valid_o !== (c >= LAT)) begin failures++; $display("FAIL mid_valid cyc=%0d got=%b exp=%b", c, fetch_valid_o, (c >= LAT)); end
            if (c >= LAT) begin
                exp = BOOT + 16'(4*(c-LAT));
                checks++;
                if (fetch_addr_o !== exp || fetch_rdata_o !== word_of(exp)) begin
                    failures++; $display("FAIL mid_word cyc=%0d got %h/%h exp %h/%h", c, fetch_addr_o, fetch_rdata_o, exp, word_of(exp));
                end
            end
            tick();
        end
    endtask

    // Model: words issued since the last redirect are delivered strictly in order; outstanding counts issued-not-delivered.
    task automatic test_random();
        int          outstanding = 0;
        int          inflight = 0;
        logic [15:0] exp_issue = BOOT;
        logic [15:0] exp_del = BOOT;
        logic [15:0] tgt, atgt, exp_maddr;
        bit          en, rdy, br, exp_valid, pop, exp_en;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en  = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 6);
            br  = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
            atgt = tgt & 16'hFFFC;
            fetch_en_i = en;
            fetch_ready_i = rdy;
            branch_i = br;
            branch_addr_i = tgt;
            if (br) exp_valid = 1'b0;
            else if (LAT == 1) exp_valid = (outstanding > 0);
            else exp_valid = ((outstanding - inflight) > 0);
            pop = exp_valid & rdy;
            exp_en = br ? en : (en && (outstanding - int'(pop) < DEPTH));
            exp_maddr = br ? atgt : exp_issue;
            @(negedge clk);
            checks++;
            if (fetch_valid_o !== exp_valid) begin
                failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, fetch_valid_o, exp_valid);
            end
            checks++;
            if (mem_en_o !== exp_en || (exp_en && mem_addr_o !== exp_maddr)) begin
                failures++; $display("FAIL rand_issue cyc=%0d got en=%b addr=%h exp en=%b addr=%h", c, mem_en_o, mem_addr_o, exp_en, exp_maddr);
            end
            if (exp_valid) begin
                checks++;
                if (fetch_addr_o !== exp_del || fetch_rdata_o !== word_of(exp_del)) begin
                    failures++; $display("FAIL rand_word cyc=%0d got %h/%h exp %h/%h", c, fetch_addr_o, fetch_rdata_o, exp_del, word_of(exp_del));
                end
            end
            tick();
            if (br) begin
                outstanding = int'(en);
                inflight = int'(en);
                exp_del = atgt;
                exp_issue = en ? atgt + 16'd4 : atgt;
            end else begin
                if (pop) begin
                    outstanding--;
                    exp_del = exp_del + 16'd4;
                end
                if (exp_en) begin
                    outstanding++;
                    exp_issue = exp_issue + 16'd4;
                end
                inflight = int'(exp_en);
            end
        end
        branch_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_branch();
        test_fetch_disable();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

Sequential instruction prefetch buffer sitting directly upstream of the instruction RAM/boot-ROM wrapper. It issues word-aligned sequential reads into the wrapper's single-cycle-latency enable/address port and captures the returned words in a small FIFO. It presents them to the core fetch stage over a valid/ready interface, and handles branch redirects by flushing buffered and in-flight data.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_WIDTH, 16, byte address width; equals the wrapper's address width, and the MSB selects boot ROM
- DATA_WIDTH, 32, instruction word width
- BOOT_ADDR, 16'h8000, fetch address loaded at reset (boot ROM base)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fetch_en_i  in  1  permits issuing new reads
- branch_i  in  1  redirect strobe, one cycle
- branch_addr_i  in  ADDR_WIDTH  redirect target; bits [1:0] ignored
- fetch_valid_o  out  1  head word available
- fetch_ready_i  in  1  core accepts head word
- fetch_rdata_o  out  DATA_WIDTH  head instruction word
- fetch_addr_o  out  ADDR_WIDTH  byte address of head word
- mem_en_o  out  1  read strobe to the RAM wrapper
- mem_addr_o  out  ADDR_WIDTH  word-aligned read address; bits [1:0] always 0
- mem_rdata_i  in  DATA_WIDTH  read data, valid the cycle after mem_en_o

## Operation
- State: next-fetch pointer pc_q, in-flight flag infl_q plus its address infl_addr_q, and a FIFO of {addr, data} with rd/wr pointers and count (clog2(DEPTH)+1 bits).
- pop = fetch_valid_o & fetch_ready_i.
- Issue (no branch): mem_en_o = fetch_en_i & (count + infl_q − pop < DEPTH). mem_addr_o = pc_q. On issue, pc_q += 4, wrapping modulo 2^ADDR_WIDTH, and infl_q is set with infl_addr_q = pc_q.
- Return: if infl_q is set, mem_rdata_i is written to the FIFO with infl_addr_q, unless consumed via fall-through (see Configuration).
- Branch (branch_i=1):
  - The FIFO is emptied, and a return arriving this cycle is discarded.
  - fetch_valid_o is forced to 0.
  - If fetch_en_i=1, the block issues at {branch_addr_i[ADDR_WIDTH-1:2],2'b00} this cycle and sets pc_q to that address + 4. Otherwise pc_q takes the aligned target and no read is issued.
- Branch has priority over pop, issue and return.
- fetch_en_i low: no new issue. An in-flight read still completes into the FIFO, and FIFO contents are retained and drainable.
- Full: the issue condition guarantees no write into a full FIFO. Pop and write in the same cycle keep count unchanged.
- Address wrap: pc_q wraps from 2^ADDR_WIDTH−4 to 0, crossing from boot ROM to RAM space with no special handling.

## Timing
- Reset values: pc_q=BOOT_ADDR, infl_q=0, count=0, fetch_valid_o=0, fetch_rdata_o=0, fetch_addr_o=0. While rst_n is low, mem_en_o=0 and mem_addr_o=BOOT_ADDR.
- RAM latency is 1 cycle. The earliest a word is visible at fetch_valid_o is issue+1 with fall-through, or issue+2 without.
- Throughput: one word per cycle sustained when fetch_ready_i is held high.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight data is lost, with no spurious fetch_valid_o after release.
- fetch_rdata_o and fetch_addr_o must hold stable while fetch_valid_o=1 and fetch_ready_i=0.

## Configuration
- FETCH_BUF_FALLTHROUGH_EN defined:
  - When the FIFO is empty and a return arrives, fetch_valid_o=1 with fetch_rdata_o=mem_rdata_i and fetch_addr_o=infl_addr_q in that same cycle.
  - If fetch_ready_i=1, the word is not written to the FIFO. Otherwise it is written and held.
- Undefined: every return is written to the FIFO first; fetch_valid_o reflects only count>0. This adds 1 cycle of latency, and all outputs come from registers.

## Test plan
- Reset release with fetch_en_i=1 and fetch_ready_i=1 → mem_addr_o sequence 0x8000, 0x8004, 0x8008… on consecutive cycles. fetch_addr_o sequence matches, first valid at cycle 2 with fall-through or cycle 3 without, then one word per cycle.
- fetch_ready_i=0 for 10 cycles → exactly DEPTH=4 reads issued (0x8000–0x800C). mem_en_o is then 0, and the head holds 0x8000 with its data stable.
- branch_i with branch_addr_i=0x0102 while 3 words are buffered and 1 is in flight → the cycle after has no stale word. The next delivered fetch_addr_o is 0x0100, then 0x0104.
- fetch_en_i dropped with 1 read in flight → that word is delivered, no further mem_en_o, and the FIFO drains to fetch_valid_o=0.
- Branch to 0xFFFC → delivered addresses 0xFFFC, then 0x0000.
- rst_n asserted with the FIFO full → all outputs at reset values within the same cycle; after release, fetching restarts at 0x8000.
